// File: rtl/vnarrow_clip.sv
// vnarrow_clip: pipelined narrowing shift/clip with rounding, saturation and half-beat packing
module vnarrow_clip #(
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH = DATA_WIDTH / 8,
  parameter int LATENCY = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_vec0,
  input  logic [DATA_WIDTH-1:0] in_vec1,
  input  logic [1:0]            in_sew,
  input  logic [1:0]            in_op,
  input  logic [1:0]            in_vxrm,
  input  logic                  in_turn,
  input  logic [BE_WIDTH-1:0]   in_be,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic [BE_WIDTH-1:0]   out_be,
  output logic                  out_sat
);
  localparam int DW = DATA_WIDTH;
  localparam int HW = DW / 2;
  localparam int HB = BE_WIDTH / 2;
  localparam int RW = DW / 16;
  logic v1, t1, v2, t2;
  logic [DW-1:0] a1, b1, x2;
  logic [1:0] sew1, op1, rm1, sew2, op2, k1, k2;
  logic [BE_WIDTH-1:0] be1, be2;
  logic [RW-1:0] r2;
  logic unused_shift_bits;
  assign unused_shift_bits = ^b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      sew1 <= '0;
      op1 <= '0;
      rm1 <= '0;
      t1 <= 1'b0;
      be1 <= '0;
    end else begin
      v1 <= in_valid;
      a1 <= in_valid ? in_vec0 : '0;
      b1 <= in_valid ? in_vec1 : '0;
      sew1 <= in_valid ? in_sew : '0;
      op1 <= in_valid ? in_op : '0;
      rm1 <= in_valid ? in_vxrm : '0;
      t1 <= in_valid & in_turn;
      be1 <= in_valid ? in_be : '0;
    end
  logic [2:0][DW-1:0] sh_a;
  logic [2:0][RW-1:0] r_a;
  for (genvar k = 0; k < 3; k++) begin : g_sh
    localparam int S = 16 << k;
    localparam int L = $clog2(S);
    for (genvar i = 0; i < RW; i++) begin : g_e
      if (i < DW / S) begin : g_v
        logic [S-1:0] v, sl, sa, sh, m;
        logic [L-1:0] d;
        logic h, lo, lo2, vd;
        assign v = a1[i*S +: S];
        assign d = b1[i*S +: L];
        assign sl = v >> d;
        assign sa = $signed(v) >>> d;
        assign sh = op1[0] ? sa : sl;
        // m masks the bits shifted out; v[d] is the new lsb of the shifted value
        assign m = (S'(1) << d) - S'(1);
        assign h = d != '0 && v[d - L'(1)];
        assign lo = |(v & m);
        assign lo2 = |(v & (m >> 1));
        assign vd = sh[0];
        assign sh_a[k][i*S +: S] = sh;
        assign r_a[k][i] = rm1 == 2'd0 ? h : rm1 == 2'd1 ? h & (lo2 | vd) : rm1 == 2'd2 ? 1'b0 : !vd & lo;
      end else begin : g_z
        assign r_a[k][i] = 1'b0;
      end
    end
  end
  assign k1 = sew1 == 2'd0 ? 2'd0 : sew1 - 2'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2 <= 1'b0;
      x2 <= '0;
      r2 <= '0;
      sew2 <= '0;
      op2 <= '0;
      t2 <= 1'b0;
      be2 <= '0;
    end else begin
      v2 <= v1;
      x2 <= sew1 == 2'd0 ? a1 : sh_a[k1];
      r2 <= sew1 == 2'd0 ? '0 : r_a[k1];
      sew2 <= sew1;
      op2 <= op1;
      t2 <= t1;
      be2 <= be1;
    end
  logic [2:0][HW-1:0] n_a;
  logic [2:0][HB-1:0] nb_a;
  logic [2:0] st_a;
  for (genvar k = 0; k < 3; k++) begin : g_cl
    localparam int S = 16 << k;
    localparam int N = S / 2;
    localparam int E = DW / S;
    logic [E-1:0] se;
    for (genvar i = 0; i < E; i++) begin : g_e
      logic [S-1:0] x;
      logic [S:0] us, ss;
      logic [N-1:0] cu, cs;
      logic [N/8-1:0] eb;
      logic ou, os;
      assign x = x2[i*S +: S];
      // one extra bit so the rounding carry saturates instead of wrapping
      assign us = {1'b0, x} + {{S{1'b0}}, r2[i]};
      assign ss = {x[S-1], x} + {{S{1'b0}}, r2[i]};
      assign ou = |us[S:N];
      assign os = !(&ss[S:N-1] || !(|ss[S:N-1]));
      assign cu = ou ? '1 : us[N-1:0];
      assign cs = os ? {ss[S], {(N-1){!ss[S]}}} : ss[N-1:0];
      assign eb = be2[i*S/8 +: N/8];
      assign n_a[k][i*N +: N] = !op2[1] ? x[N-1:0] : op2[0] ? cs : cu;
      assign nb_a[k][i*N/8 +: N/8] = eb;
      assign se[i] = op2[1] & (op2[0] ? os : ou) & (|eb);
    end
    assign st_a[k] = |se;
  end
  logic [HW-1:0] nv;
  logic [HB-1:0] nb;
  assign k2 = sew2 == 2'd0 ? 2'd0 : sew2 - 2'd1;
  assign nv = n_a[k2];
  assign nb = nb_a[k2];
  logic d_v [LATENCY-2];
  logic d_s [LATENCY-2];
  logic [DW-1:0] d_x [LATENCY-2];
  logic [BE_WIDTH-1:0] d_b [LATENCY-2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int j = 0; j < LATENCY - 2; j++) begin
        d_v[j] <= 1'b0;
        d_s[j] <= 1'b0;
        d_x[j] <= '0;
        d_b[j] <= '0;
      end
    end else begin
      d_v[0] <= v2;
      d_x[0] <= sew2 == 2'd0 ? x2 : t2 ? {nv, {HW{1'b0}}} : {{HW{1'b0}}, nv};
      d_b[0] <= sew2 == 2'd0 ? be2 : t2 ? {nb, {HB{1'b0}}} : {{HB{1'b0}}, nb};
      d_s[0] <= sew2 != 2'd0 && st_a[k2];
      for (int j = 1; j < LATENCY - 2; j++) begin
        d_v[j] <= d_v[j-1];
        d_s[j] <= d_s[j-1];
        d_x[j] <= d_x[j-1];
        d_b[j] <= d_b[j-1];
      end
    end
  assign out_valid = d_v[LATENCY-3];
  assign out_sat = d_s[LATENCY-3];
  assign out_vec = d_x[LATENCY-3];
  assign out_be = d_b[LATENCY-3];
endmodule

// File: tb/tb_vnarrow_clip.sv
// tb_vnarrow_clip: directed-vector bench for vnarrow_clip
module tb_vnarrow_clip;
  localparam int LAT = 6;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_turn, out_valid, out_sat;
  logic [63:0] in_vec0, in_vec1, out_vec;
  logic [1:0] in_sew, in_op, in_vxrm;
  logic [7:0] in_be, out_be;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [63:0] a, b;
    logic [1:0] sew, op, rm;
    logic turn;
    logic [7:0] be;
    logic [63:0] ev;
    logic [7:0] eb;
    logic es;
  } vec_t;
  vec_t tv[$];
  vnarrow_clip #(.DATA_WIDTH(64), .BE_WIDTH(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec0(in_vec0), .in_vec1(in_vec1),
    .in_sew(in_sew), .in_op(in_op), .in_vxrm(in_vxrm), .in_turn(in_turn), .in_be(in_be),
    .out_valid(out_valid), .out_vec(out_vec), .out_be(out_be), .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic add(input logic [63:0] a, b, input logic [1:0] sew, op, rm, input logic turn,
                     input logic [7:0] be, input logic [63:0] ev, input logic [7:0] eb, input logic es);
    tv.push_back('{a, b, sew, op, rm, turn, be, ev, eb, es});
  endtask
  task automatic put(input int k);
    in_valid = 1'b1;
    in_vec0 = tv[k].a;
    in_vec1 = tv[k].b;
    in_sew = tv[k].sew;
    in_op = tv[k].op;
    in_vxrm = tv[k].rm;
    in_turn = tv[k].turn;
    in_be = tv[k].be;
  endtask
  task automatic idle();
    in_valid = 1'b0;
    in_vec0 = '0;
    in_vec1 = '0;
    in_sew = '0;
    in_op = '0;
    in_vxrm = '0;
    in_turn = 1'b0;
    in_be = '0;
  endtask
  task automatic single(input int k, input string p);
    @(negedge clk) put(k);
    @(posedge clk) #1 idle();
    repeat (LAT - 2) @(posedge clk);
    #1 chk({p, "_early"}, out_valid, 0);
    @(posedge clk) #1;
    chk({p, "_v"}, out_valid, 1);
    chk({p, "_vec"}, out_vec, tv[k].ev);
    chk({p, "_be"}, out_be, tv[k].eb);
    chk({p, "_sat"}, out_sat, tv[k].es);
  endtask
  initial begin
    #300000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    add(64'h0123456789ABCDEF, 64'hFFFF, 0, 3, 0, 1, 8'h5A, 64'h0123456789ABCDEF, 8'h5A, 0);
    add(64'hFF7F, 0, 1, 3, 0, 0, 8'hFF, 64'h80, 8'h0F, 1);
    add(64'h0001_2345_0000_0100, 64'h4_0000_0004, 2, 0, 0, 0, 8'hFF, 64'h1234_0010, 8'h0F, 0);
    add(64'h1_0000_0000, 0, 3, 2, 0, 0, 8'hFF, 64'hFFFF_FFFF, 8'h0F, 1);
    add(64'hDEADBEEF00C0FFEE, 0, 0, 0, 0, 0, 8'hC3, 64'hDEADBEEF00C0FFEE, 8'hC3, 0);
    add(64'hFF7F, 0, 1, 3, 0, 1, 8'hFE, 64'h0000_0080_0000_0000, 8'hE0, 0);
    add(64'h0001_2345_0000_0100, 64'h4_0000_0004, 2, 0, 0, 1, 8'hFF, 64'h1234_0010_0000_0000, 8'hF0, 0);
    add(64'hFFFF_FFFF_8000_0000, 64'h20, 3, 2, 0, 1, 8'hFF, 64'hFFFF_FFFF_0000_0000, 8'hF0, 1);
    add(64'h12, 64'h2, 1, 2, 0, 0, 8'hFF, 64'h05, 8'h0F, 0);
    add(64'h12, 64'h2, 1, 2, 1, 1, 8'hFF, 64'h0000_0004_0000_0000, 8'hF0, 0);
    add(64'h12, 64'h2, 1, 2, 2, 0, 8'hFF, 64'h04, 8'h0F, 0);
    add(64'h12, 64'h2, 1, 2, 3, 1, 8'hFF, 64'h0000_0005_0000_0000, 8'hF0, 0);
    add(64'h17, 64'h2, 1, 2, 0, 0, 8'hFF, 64'h06, 8'h0F, 0);
    add(64'h16, 64'h2, 1, 2, 1, 0, 8'hFF, 64'h06, 8'h0F, 0);
    add(64'hF234, 64'hFC, 1, 1, 0, 0, 8'hFF, 64'hFF, 8'h0F, 0);
    add(64'h0001_0000, 0, 2, 3, 0, 1, 8'hFF, 64'h0000_7FFF_0000_0000, 8'hF0, 1);
    add(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1, 0, 0, 8'hFF, 64'hFFFF_FFFF, 8'h0F, 0);
    add(64'h18, 64'h4, 1, 0, 0, 1, 8'hFF, 64'h0000_0001_0000_0000, 8'hF0, 0);
    rst_n = 1'b0;
    idle();
    @(posedge clk) #1;
    chk("rst_v", out_valid, 0);
    chk("rst_vec", out_vec, 0);
    chk("rst_be", out_be, 0);
    chk("rst_sat", out_sat, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < tv.size(); k++) single(k, $sformatf("t%0d", k));
    @(negedge clk);
    in_vec0 = 64'h7FFF_7FFF_7FFF_7FFF;
    in_sew = 2'd1;
    in_op = 2'd3;
    in_turn = 1'b1;
    in_be = 8'hFF;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk) #1;
      chk("idle_vec", out_vec, 0);
      chk("idle_ctl", {out_valid, out_sat, out_be}, 0);
    end
    @(negedge clk) idle();
    fork
      begin
        for (int k = 0; k < tv.size(); k++) @(negedge clk) put(k);
        @(negedge clk) idle();
      end
      begin
        for (int w = 0; w < 20 && !out_valid; w++) @(posedge clk) #1;
        chk("s_start", out_valid, 1);
        for (int k = 0; k < tv.size(); k++) begin
          chk($sformatf("s%0d_v", k), out_valid, 1);
          chk($sformatf("s%0d_vec", k), out_vec, tv[k].ev);
          chk($sformatf("s%0d_be", k), out_be, tv[k].eb);
          chk($sformatf("s%0d_sat", k), out_sat, tv[k].es);
          @(posedge clk) #1;
        end
        chk("s_end", out_valid, 0);
      end
    join
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      put(k);
      @(negedge clk);
    end
    idle();
    chk("r_pre_v", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_v", out_valid, 0);
    chk("r_vec", out_vec, 0);
    chk("r_be", out_be, 0);
    chk("r_sat", out_sat, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 2; c++) @(posedge clk) #1 chk("r_stale", out_valid, 0);
    single(3, "r_beat");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
